// File: rtl/int_mul_pkg.sv
// Shared widths, limits and helpers for the pipelined integer multiplier.
// The stored word is {n, z, product}; the read word adds {C, V} on top.
package int_mul_pkg;

  // Legal multiply pipeline depths.
  localparam int STAGES_MIN = 1;
  localparam int STAGES_MAX = 8;

  // Width of one result-buffer entry: {n, z, product[2*DATA_W-1:0]}.
  function automatic int storedWidth(input int dataW);
    return 2 * dataW + 2;
  endfunction

  // Width of a read port: {C, V, n, z, product[2*DATA_W-1:0]}.
  function automatic int outWidth(input int dataW);
    return 2 * dataW + 4;
  endfunction

  // True when the requested pipeline depth is supported.
  function automatic bit stagesInRange(input int stages);
    return (stages >= STAGES_MIN) && (stages <= STAGES_MAX);
  endfunction

  // Flag pair carried ahead of the product in every stored entry.
  typedef struct packed {
    logic n;
    logic z;
  } resFlags_t;

endpackage

// File: rtl/RAM_func.sv
// Result buffer: one synchronous write port and two asynchronous read ports.
// Read data is registered by the owner, so reads here are purely combinational.
module RAM_func #(
  parameter int ADDRS_WIDTH = 4,
  parameter int DATA_WIDTH  = 66
) (
  input  logic                   CLK,
  input  logic                   wren,
  input  logic [ADDRS_WIDTH-1:0] wraddrs,
  input  logic [DATA_WIDTH-1:0]  wrdata,
  input  logic [ADDRS_WIDTH-1:0] rdaddrsA,
  output logic [DATA_WIDTH-1:0]  rddataA,
  input  logic [ADDRS_WIDTH-1:0] rdaddrsB,
  output logic [DATA_WIDTH-1:0]  rddataB
);

  localparam int DEPTH = 2 ** ADDRS_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write the committing entry on the rising edge.
  // NOTE: the array deliberately has no reset; resetting a memory turns it into
  // a wide bank of flops and the contents are allowed to survive RESET.
  always_ff @(posedge CLK) begin
    if (wren) begin
      mem[wraddrs] <= wrdata;
    end
  end

  assign rddataA = mem[rdaddrsA];
  assign rddataB = mem[rdaddrsB];

endmodule

// File: rtl/int_mul_stages.sv
// Multiply pipeline: extends both operands, forms the full signed product and
// carries {valid, addr, stored word} through STAGES registers. The final stage
// is the commit port into the result buffer. The pipeline never stalls.
module int_mul_stages
  import int_mul_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDRS_W = 4,
  parameter int STAGES  = 3
) (
  input  logic                             CLK,
  input  logic                             RESET,
  input  logic                             wren,
  input  logic [ADDRS_W-1:0]               wraddrs,
  input  logic                             sextA,
  input  logic                             sextB,
  input  logic [DATA_W-1:0]                oprndA,
  input  logic [DATA_W-1:0]                oprndB,
  output logic [STAGES-1:0]                stgValid,
  output logic [STAGES-1:0][ADDRS_W-1:0]   stgAddr,
  output logic                             commitEn,
  output logic [ADDRS_W-1:0]               commitAddr,
  output logic [storedWidth(DATA_W)-1:0]   commitData
);

  localparam int STORED_W = storedWidth(DATA_W);
  // The signed product of two (DATA_W+1)-bit operands needs 2*DATA_W+2 bits.
  localparam int PROD_W   = 2 * DATA_W + 2;

  // One pipeline slot.
  typedef struct packed {
    logic               valid;
    logic [ADDRS_W-1:0] addr;
    logic [STORED_W-1:0] prod;
  } stageRec_t;

  logic [DATA_W:0]   extA;
  logic [DATA_W:0]   extB;
  logic [PROD_W-1:0] fullProd;
  resFlags_t         flags;
  stageRec_t         issueRec;
  stageRec_t         stg [STAGES];

  // Extend operands, multiply at full width and pack {n, z, product}.
  // NOTE: every variable of a combinational block gets a value on every path
  // (the struct default below), otherwise synthesis infers a latch.
  always_comb begin
    issueRec = '0;
    extA     = {sextA & oprndA[DATA_W-1], oprndA};
    extB     = {sextB & oprndB[DATA_W-1], oprndB};
    // Sign-extending both factors to the product width makes the truncated
    // unsigned product equal to the two's-complement signed product.
    fullProd = {{(DATA_W+1){extA[DATA_W]}}, extA} *
               {{(DATA_W+1){extB[DATA_W]}}, extB};
    flags.n  = fullProd[2*DATA_W];
    flags.z  = ~|fullProd;
    issueRec.valid = wren;
    issueRec.addr  = wraddrs;
    issueRec.prod  = {flags, fullProd[2*DATA_W-1:0]};
  end

  // Shift slots down the pipeline every cycle; reset drops anything in flight.
  // NOTE: sequential state uses non-blocking assignments so every slot samples
  // its predecessor's pre-edge value, independent of statement order.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int s = 0; s < STAGES; s++) begin
        stg[s] <= '0;
      end
    end else begin
      stg[0] <= issueRec;
      for (int s = 1; s < STAGES; s++) begin
        stg[s] <= stg[s-1];
      end
    end
  end

  // Expose slot occupancy for the hazard check in the top.
  always_comb begin
    stgValid = '0;
    stgAddr  = '0;
    for (int s = 0; s < STAGES; s++) begin
      stgValid[s] = stg[s].valid;
      stgAddr[s]  = stg[s].addr;
    end
  end

  assign commitEn   = stg[STAGES-1].valid;
  assign commitAddr = stg[STAGES-1].addr;
  assign commitData = stg[STAGES-1].prod;

endmodule

// File: rtl/int_mul_pipe.sv
// Pipelined integer multiplier with a thread-indexed result buffer and two
// hazard-checked read ports. Reads of any entry with a multiply in flight (or
// being issued this cycle) pull ready low and freeze both read registers.
module int_mul_pipe
  import int_mul_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDRS_W = 4,
  parameter int STAGES  = 3
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         wren,
  input  logic [ADDRS_W-1:0]           wraddrs,
  input  logic                         Sext_SrcA_q2,
  input  logic                         Sext_SrcB_q2,
  input  logic [DATA_W-1:0]            oprndA,
  input  logic [DATA_W-1:0]            oprndB,
  input  logic                         C,
  input  logic                         V,
  input  logic                         rdenA,
  input  logic                         rdenB,
  input  logic [ADDRS_W-1:0]           rdaddrsA,
  input  logic [ADDRS_W-1:0]           rdaddrsB,
  output logic [outWidth(DATA_W)-1:0]  rddataA,
  output logic [outWidth(DATA_W)-1:0]  rddataB,
  output logic                         ready
);

  localparam int STORED_W = storedWidth(DATA_W);
  localparam int DEPTH    = 2 ** ADDRS_W;

  if (!stagesInRange(STAGES)) begin : gBadStages
    $error("int_mul_pipe: STAGES must be within 1..8");
  end

  logic [STAGES-1:0]              stgValid;
  logic [STAGES-1:0][ADDRS_W-1:0] stgAddr;
  logic                           commitEn;
  logic [ADDRS_W-1:0]             commitAddr;
  logic [STORED_W-1:0]            commitData;
  logic [STORED_W-1:0]            ramA;
  logic [STORED_W-1:0]            ramB;
  logic [STORED_W-1:0]            holdA;
  logic [STORED_W-1:0]            holdB;
  logic [DEPTH-1:0]               pending;
  logic                           hazard;

  int_mul_stages #(
    .DATA_W  (DATA_W),
    .ADDRS_W (ADDRS_W),
    .STAGES  (STAGES)
  ) uStages (
    .CLK        (CLK),
    .RESET      (RESET),
    .wren       (wren),
    .wraddrs    (wraddrs),
    .sextA      (Sext_SrcA_q2),
    .sextB      (Sext_SrcB_q2),
    .oprndA     (oprndA),
    .oprndB     (oprndB),
    .stgValid   (stgValid),
    .stgAddr    (stgAddr),
    .commitEn   (commitEn),
    .commitAddr (commitAddr),
    .commitData (commitData)
  );

  RAM_func #(
    .ADDRS_WIDTH (ADDRS_W),
    .DATA_WIDTH  (STORED_W)
  ) uRam (
    .CLK      (CLK),
    .wren     (commitEn),
    .wraddrs  (commitAddr),
    .wrdata   (commitData),
    .rdaddrsA (rdaddrsA),
    .rddataA  (ramA),
    .rdaddrsB (rdaddrsB),
    .rddataB  (ramB)
  );

  // Mark every entry owned by an in-flight or just-issued multiply. The final
  // slot is included: an entry committing this edge is still unreadable.
  always_comb begin
    pending = '0;
    for (int s = 0; s < STAGES; s++) begin
      if (stgValid[s]) begin
        pending[stgAddr[s]] = 1'b1;
      end
    end
    if (wren) begin
      pending[wraddrs] = 1'b1;
    end
  end

  assign hazard = (rdenA & pending[rdaddrsA]) | (rdenB & pending[rdaddrsB]);
  // While RESET is low nothing is in flight, so the block reports ready.
  assign ready  = ~RESET | ~hazard;

  // Capture read data for enabled ports; a hazard on either port freezes both
  // so the requester sees a consistent pair once it re-presents the read.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      holdA <= '0;
      holdB <= '0;
    end else if (!hazard) begin
      if (rdenA) begin
        holdA <= ramA;
      end
      if (rdenB) begin
        holdB <= ramB;
      end
    end
  end

  assign rddataA = {C, V, holdA};
  assign rddataB = {C, V, holdB};

endmodule

// File: tb/tb_int_mul_pipe.sv
// Self-checking bench for int_mul_pipe: directed scenarios plus a randomized
// phase, all compared against a transaction-level reference model.
module tb_int_mul_pipe;

  localparam int DATA_W   = 32;
  localparam int ADDRS_W  = 4;
  localparam int STAGES   = 3;
  localparam int STORED_W = 2 * DATA_W + 2;
  localparam int OUT_W    = 2 * DATA_W + 4;
  localparam int DEPTH    = 2 ** ADDRS_W;

  logic               CLK = 1'b0;
  logic               RESET;
  logic               wren;
  logic [ADDRS_W-1:0] wraddrs;
  logic               Sext_SrcA_q2;
  logic               Sext_SrcB_q2;
  logic [DATA_W-1:0]  oprndA;
  logic [DATA_W-1:0]  oprndB;
  logic               C;
  logic               V;
  logic               rdenA;
  logic               rdenB;
  logic [ADDRS_W-1:0] rdaddrsA;
  logic [ADDRS_W-1:0] rdaddrsB;
  logic [OUT_W-1:0]   rddataA;
  logic [OUT_W-1:0]   rddataB;
  logic               ready;

  int unsigned passCnt  = 0;
  int unsigned totalCnt = 0;

  // Reference model state: in-flight multiplies with edges left to commit.
  typedef struct {
    logic [ADDRS_W-1:0]  addr;
    logic [STORED_W-1:0] data;
    int                  left;
  } op_t;

  op_t                 inflight[$];
  logic [STORED_W-1:0] ramModel [DEPTH];
  logic [STORED_W-1:0] expA;
  logic [STORED_W-1:0] expB;
  logic                modelReady;
  logic                dutReady;
  logic                rdy [8];

  always #5 CLK = ~CLK;

  int_mul_pipe #(
    .DATA_W  (DATA_W),
    .ADDRS_W (ADDRS_W),
    .STAGES  (STAGES)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .wren         (wren),
    .wraddrs      (wraddrs),
    .Sext_SrcA_q2 (Sext_SrcA_q2),
    .Sext_SrcB_q2 (Sext_SrcB_q2),
    .oprndA       (oprndA),
    .oprndB       (oprndB),
    .C            (C),
    .V            (V),
    .rdenA        (rdenA),
    .rdenB        (rdenB),
    .rdaddrsA     (rdaddrsA),
    .rdaddrsB     (rdaddrsB),
    .rddataA      (rddataA),
    .rddataB      (rddataB),
    .ready        (ready)
  );

  task automatic check(input string tag, input logic [OUT_W-1:0] got,
                       input logic [OUT_W-1:0] exp);
    totalCnt++;
    if (got === exp) begin
      passCnt++;
    end else begin
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Stored word from plain integer arithmetic: value of each operand as a
  // mathematical integer, multiply, then read off sign, zero and low bits.
  function automatic logic [STORED_W-1:0] refStore(input logic [DATA_W-1:0] a,
      input logic [DATA_W-1:0] b, input logic sa, input logic sb);
    logic signed [127:0] av;
    logic signed [127:0] bv;
    logic signed [127:0] p;
    av = {96'b0, a};
    bv = {96'b0, b};
    if (sa && a[DATA_W-1]) av = av - 128'sh1_0000_0000;
    if (sb && b[DATA_W-1]) bv = bv - 128'sh1_0000_0000;
    p = av * bv;
    return {p < 0, p == 0, p[2*DATA_W-1:0]};
  endfunction

  function automatic logic calcReady();
    logic pendA;
    logic pendB;
    pendA = wren && (wraddrs == rdaddrsA);
    pendB = wren && (wraddrs == rdaddrsB);
    foreach (inflight[i]) begin
      if (inflight[i].addr == rdaddrsA) pendA = 1'b1;
      if (inflight[i].addr == rdaddrsB) pendB = 1'b1;
    end
    return !((rdenA && pendA) || (rdenB && pendB));
  endfunction

  // Advance the model across one rising edge.
  task automatic modelEdge();
    if (modelReady) begin
      if (rdenA) expA = ramModel[rdaddrsA];
      if (rdenB) expB = ramModel[rdaddrsB];
    end
    foreach (inflight[i]) inflight[i].left--;
    while (inflight.size() > 0 && inflight[0].left == 0) begin
      ramModel[inflight[0].addr] = inflight[0].data;
      void'(inflight.pop_front());
    end
    if (wren) begin
      inflight.push_back('{addr: wraddrs,
                           data: refStore(oprndA, oprndB, Sext_SrcA_q2, Sext_SrcB_q2),
                           left: STAGES});
    end
  endtask

  // One cycle: caller has set inputs at the falling edge.
  task automatic tick();
    #1;
    modelReady = calcReady();
    dutReady   = ready;
    check("ready", OUT_W'(ready), OUT_W'(modelReady));
    @(posedge CLK);
    modelEdge();
    #1;
    check("rddataA", rddataA, {C, V, expA});
    check("rddataB", rddataB, {C, V, expB});
    @(negedge CLK);
  endtask

  task automatic clearIn();
    wren  = 1'b0;
    rdenA = 1'b0;
    rdenB = 1'b0;
  endtask

  task automatic issue(input logic [ADDRS_W-1:0] addr, input logic [DATA_W-1:0] a,
                       input logic [DATA_W-1:0] b, input logic sa, input logic sb);
    wren         = 1'b1;
    wraddrs      = addr;
    oprndA       = a;
    oprndB       = b;
    Sext_SrcA_q2 = sa;
    Sext_SrcB_q2 = sb;
  endtask

  // Issue, wait out the pipeline, then read port A in the cycle after commit.
  task automatic issueAndRead(input logic [ADDRS_W-1:0] addr, input logic [DATA_W-1:0] a,
                              input logic [DATA_W-1:0] b, input logic sa, input logic sb);
    clearIn();
    issue(addr, a, b, sa, sb);
    tick();
    clearIn();
    repeat (STAGES) tick();
    rdenA    = 1'b1;
    rdaddrsA = addr;
    tick();
    check("issue_read_ready", OUT_W'(dutReady), OUT_W'(1'b1));
    clearIn();
  endtask

  function automatic logic [DATA_W-1:0] pickOp();
    case ($urandom_range(0, 4))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    RESET = 1'b0;
    C = 1'b0; V = 1'b0;
    wraddrs = '0; rdaddrsA = '0; rdaddrsB = '0;
    oprndA = '0; oprndB = '0; Sext_SrcA_q2 = 1'b0; Sext_SrcB_q2 = 1'b0;
    expA = '0; expB = '0;
    // Issue and read the same entry during reset: ready must still be high.
    wren = 1'b1; rdenA = 1'b1; rdenB = 1'b1;
    #7;
    check("reset_rddataA", rddataA, '0);
    check("reset_rddataB", rddataB, '0);
    check("reset_ready", OUT_W'(ready), OUT_W'(1'b1));
    @(negedge CLK);
    clearIn();
    RESET = 1'b1;

    // Give every entry a defined value.
    for (int i = 0; i < DEPTH; i++) begin
      issue(ADDRS_W'(i), $urandom, $urandom, 1'($urandom), 1'($urandom));
      tick();
    end
    clearIn();
    repeat (STAGES + 1) tick();

    // Entry 1 gets a known value for the mixed-port scenario.
    issueAndRead(4'd1, 32'd100, 32'd7, 1'b0, 1'b0);
    check("entry1_value", OUT_W'(rddataA[STORED_W-1:0]), OUT_W'(66'h2BC));

    // Unsigned full-scale square.
    issueAndRead(4'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check("unsigned_max", OUT_W'(rddataA[STORED_W-1:0]), OUT_W'({2'b00, 64'hFFFF_FFFE_0000_0001}));

    // Signed: -1 * 2.
    issueAndRead(4'd6, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 1'b1);
    check("signed_neg2", OUT_W'(rddataA[STORED_W-1:0]), OUT_W'({2'b10, 64'hFFFF_FFFF_FFFF_FFFE}));

    // Mixed: signed -2^31 times unsigned 2^32-1.
    issueAndRead(4'd8, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
    check("mixed_sign", OUT_W'(rddataA[STORED_W-1:0]), OUT_W'({2'b10, 64'h8000_0000_8000_0000}));

    // Zero product with C/V passthrough.
    C = 1'b1; V = 1'b0;
    issueAndRead(4'd9, 32'h1234_5678, 32'h0, 1'b1, 1'b1);
    check("zero_cv", rddataA, {1'b1, 1'b0, 1'b0, 1'b1, 64'h0});
    C = 1'b0;

    // Hazard: single issue to entry 3, read from the next cycle.
    issue(4'd3, 32'd3, 32'd5, 1'b0, 1'b0);
    tick();
    clearIn();
    rdenA = 1'b1; rdaddrsA = 4'd3;
    for (int c = 1; c <= 4; c++) begin
      tick();
      rdy[c] = dutReady;
    end
    clearIn();
    for (int c = 1; c <= 3; c++) check("hazard_stall", OUT_W'(rdy[c]), OUT_W'(1'b0));
    check("hazard_release", OUT_W'(rdy[4]), OUT_W'(1'b1));
    check("hazard_data", OUT_W'(rddataA[STORED_W-1:0]), OUT_W'(66'hF));

    // Back-to-back issues to entry 3; last one wins.
    issue(4'd3, 32'd7, 32'd9, 1'b0, 1'b0);
    tick();
    issue(4'd3, 32'd2, 32'd2, 1'b0, 1'b0);
    rdenA = 1'b1; rdaddrsA = 4'd3;
    tick();
    rdy[1] = dutReady;
    wren = 1'b0;
    for (int c = 2; c <= 5; c++) begin
      tick();
      rdy[c] = dutReady;
    end
    clearIn();
    for (int c = 1; c <= 4; c++) check("b2b_stall", OUT_W'(rdy[c]), OUT_W'(1'b0));
    check("b2b_release", OUT_W'(rdy[5]), OUT_W'(1'b1));
    check("b2b_data", OUT_W'(rddataA[STORED_W-1:0]), OUT_W'(66'h4));

    // Mixed ports: A clean, B pending; both stall, then both update together.
    issue(4'd2, 32'd11, 32'd13, 1'b0, 1'b0);
    tick();
    clearIn();
    rdenA = 1'b1; rdaddrsA = 4'd1;
    rdenB = 1'b1; rdaddrsB = 4'd2;
    for (int c = 1; c <= 4; c++) begin
      tick();
      rdy[c] = dutReady;
      if (c == 3) check("mixed_holdA", OUT_W'(rddataA[STORED_W-1:0]), OUT_W'(66'h4));
    end
    clearIn();
    check("mixed_stall", OUT_W'(rdy[3]), OUT_W'(1'b0));
    check("mixed_release", OUT_W'(rdy[4]), OUT_W'(1'b1));
    check("mixed_dataA", OUT_W'(rddataA[STORED_W-1:0]), OUT_W'(66'h2BC));
    check("mixed_dataB", OUT_W'(rddataB[STORED_W-1:0]), OUT_W'(66'h8F));

    // Reset mid-operation: the in-flight write to entry 7 must be discarded.
    issueAndRead(4'd7, 32'hAA, 32'd1, 1'b0, 1'b0);
    issue(4'd7, 32'h55, 32'd3, 1'b0, 1'b0);
    tick();
    clearIn();
    tick();
    RESET = 1'b0;
    wren = 1'b1; wraddrs = 4'd7; rdenA = 1'b1; rdaddrsA = 4'd7;
    #1;
    check("midreset_rddataA", rddataA, '0);
    check("midreset_rddataB", rddataB, '0);
    check("midreset_ready", OUT_W'(ready), OUT_W'(1'b1));
    @(posedge CLK);
    #1;
    check("midreset_hold", rddataA, '0);
    @(negedge CLK);
    inflight.delete();
    expA = '0; expB = '0;
    clearIn();
    RESET = 1'b1;
    repeat (STAGES + 1) tick();
    rdenA = 1'b1; rdaddrsA = 4'd7;
    tick();
    clearIn();
    check("reset_keeps_ram", OUT_W'(rddataA[STORED_W-1:0]), OUT_W'(66'hAA));

    // Randomized traffic concentrated on a few entries to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      wren         = ($urandom_range(0, 1) == 1);
      wraddrs      = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
      oprndA       = pickOp();
      oprndB       = pickOp();
      Sext_SrcA_q2 = 1'($urandom);
      Sext_SrcB_q2 = 1'($urandom);
      rdenA        = ($urandom_range(0, 2) != 0);
      rdenB        = ($urandom_range(0, 2) != 0);
      rdaddrsA     = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
      rdaddrsB     = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
      C            = 1'($urandom);
      V            = 1'($urandom);
      tick();
    end

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
